tia_horizontal_sequencer: RTL

- Horizontal line sequencer for the TIA core. It divides the colour clock into a four-phase cycle and emits the phi1/phi2 enable strobes that the biphase-clocked blocks use.
- It advances a 57-count horizontal counter, giving a 228-colour-clock line, and decodes HBLANK, HSYNC and colour burst from it.
- It arbitrates the CPU line-timing strobes: WSYNC (halt the CPU until the next line), RSYNC (restart the line) and HMOVE (extend HBLANK).

---
 rtl/tia_timing_pkg.sv | 21 ++
 rtl/tia_phase_divider.sv | 22 ++
 rtl/tia_horizontal_sequencer.sv | 79 +++++++
 3 files changed

// File: rtl/tia_timing_pkg.sv
// Horizontal timing constants shared by the sequencer, playfield and motion blocks.
package tia_timing_pkg;

  localparam int LINE_COUNTS      = 57;
  localparam int CLOCKS_PER_COUNT = 4;
  localparam int LINE_CLOCKS      = LINE_COUNTS * CLOCKS_PER_COUNT;
  localparam int HSYNC_START      = 4;
  localparam int HSYNC_END        = 8;
  localparam int CB_START         = 8;
  localparam int CB_END           = 12;
  localparam int HBLANK_END       = 17;
  localparam int HBLANK_LATE_END  = 19;

  // Half-open window test on a horizontal count: lo <= h < hi.
  function automatic logic in_window(input logic [5:0] h,
                                     input logic [5:0] lo,
                                     input logic [5:0] hi);
    return (h >= lo) && (h < hi);
  endfunction

endpackage

// File: rtl/tia_phase_divider.sv
// Four-phase divider of the colour clock producing the phi1/phi2 strobes and the count-advance enable.
module tia_phase_divider (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  output logic [1:0] phase,
  output logic       phi1,
  output logic       phi2,
  output logic       adv
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     phase <= 2'd0;
    else if (restart) phase <= 2'd0;
    else              phase <= phase + 2'd1;
  end

  assign phi1 = (phase == 2'd0);
  assign phi2 = (phase == 2'd2);
  assign adv  = (phase == 2'd3);

endmodule

// File: rtl/tia_horizontal_sequencer.sv
// TIA horizontal line sequencer: 57-count line counter, HBLANK/HSYNC/burst decode and WSYNC/RSYNC/HMOVE arbitration.
module tia_horizontal_sequencer
  import tia_timing_pkg::*;
#(
  parameter int LINE_COUNTS_P     = LINE_COUNTS,
  parameter int HSYNC_START_P     = HSYNC_START,
  parameter int HSYNC_END_P       = HSYNC_END,
  parameter int CB_START_P        = CB_START,
  parameter int CB_END_P          = CB_END,
  parameter int HBLANK_END_P      = HBLANK_END,
  parameter int HBLANK_LATE_END_P = HBLANK_LATE_END
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wsync,
  input  logic       rsync,
  input  logic       hmove,
  output logic       phi1,
  output logic       phi2,
  output logic [5:0] hcount,
  output logic       hblank,
  output logic       hsync,
  output logic       cburst,
  output logic       eol,
  output logic       rdy,
  output logic       late_hblank
);

  localparam logic [5:0] LAST_COUNT = 6'(LINE_COUNTS_P - 1);
  localparam logic [5:0] HS_LO      = 6'(HSYNC_START_P);
  localparam logic [5:0] HS_HI      = 6'(HSYNC_END_P);
  localparam logic [5:0] CB_LO      = 6'(CB_START_P);
  localparam logic [5:0] CB_HI      = 6'(CB_END_P);
  localparam logic [5:0] HB_NORM    = 6'(HBLANK_END_P);
  localparam logic [5:0] HB_LATE    = 6'(HBLANK_LATE_END_P);

  logic [1:0] phase;
  logic       adv;
  logic       halt;
  logic       late;

  tia_phase_divider u_phase (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (rsync),
    .phase   (phase),
    .phi1    (phi1),
    .phi2    (phi2),
    .adv     (adv)
  );

  assign eol = adv && (hcount == LAST_COUNT);

  // rsync outranks everything; set beats the eol clear so a strobe on the last clock carries into the new line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount <= 6'd0;
      halt   <= 1'b0;
      late   <= 1'b0;
    end else if (rsync) begin
      hcount <= 6'd0;
      halt   <= 1'b0;
      late   <= 1'b0;
    end else begin
      if (adv) hcount <= eol ? 6'd0 : hcount + 6'd1;
      if (wsync)    halt <= 1'b1;
      else if (eol) halt <= 1'b0;
      if (hmove)    late <= 1'b1;
      else if (eol) late <= 1'b0;
    end
  end

  assign hsync       = in_window(hcount, HS_LO, HS_HI);
  assign cburst      = in_window(hcount, CB_LO, CB_HI);
  assign hblank      = hcount < (late ? HB_LATE : HB_NORM);
  assign rdy         = ~halt;
  assign late_hblank = late;

endmodule
